// File: rtl/led_timing_generator_pkg.sv
// Shared state encoding, default LED actor timing (12 MHz clock) and counter sizing helper.
package led_timing_generator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam int unsigned CLOCK_HZ   = 12_000_000;
  localparam int unsigned BAUD_RATE  = 115_200;
  localparam int unsigned LED_BIT_HZ = 750_000;
  localparam int unsigned FRAME_HZ   = 60;

  localparam int unsigned DEF_SEGMENTS_PER_BIT = 4;
  localparam int unsigned DEF_UART_DIVISOR     = CLOCK_HZ / BAUD_RATE;
  localparam int unsigned DEF_SEGMENT_DIVISOR  = CLOCK_HZ / (LED_BIT_HZ * DEF_SEGMENTS_PER_BIT);
  localparam int unsigned DEF_BITS_PER_LED     = 24;
  localparam int unsigned DEF_LED_COUNT        = 60;
  localparam int unsigned DEF_RESET_SEGMENTS   = 240;
  localparam int unsigned DEF_FRAME_DIVISOR    = CLOCK_HZ / FRAME_HZ;

  // Bits needed to hold 0..max_value; never returns zero so degenerate counters still elaborate.
  function automatic int unsigned cnt_width(input int unsigned max_value);
    return (max_value < 1) ? 1 : $clog2(max_value + 1);
  endfunction

endpackage

// File: rtl/led_timing_generator_strobe_divider.sv
// Modulo-N counter with synchronous clear and count enable; pulses strobe for one cycle at STROBE_AT.
// A cleared cycle never strobes, so a clear arriving on the strobe point suppresses it.
module led_timing_generator_strobe_divider
  import led_timing_generator_pkg::*;
#(
  parameter int unsigned N         = 2,
  parameter int unsigned STROBE_AT = N - 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic strobe
);

  localparam int unsigned W = cnt_width(N - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = (cnt_q == W'(N - 1)) ? '0 : cnt_q + W'(1);
    end
  end

  assign strobe = count_en && !clear && (cnt_q == W'(STROBE_AT));

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_timing_generator.sv
// LED actor timing: UART bit-centre sampling resynchronised to RX edges, plus a framed
// IDLE/SHIFT/LATCH sequencer emitting segment/bit/word strobes, encoder latch window and overrun.
module led_timing_generator
  import led_timing_generator_pkg::*;
#(
  parameter int unsigned UART_DIVISOR     = DEF_UART_DIVISOR,
  parameter int unsigned SEGMENT_DIVISOR  = DEF_SEGMENT_DIVISOR,
  parameter int unsigned SEGMENTS_PER_BIT = DEF_SEGMENTS_PER_BIT,
  parameter int unsigned BITS_PER_LED     = DEF_BITS_PER_LED,
  parameter int unsigned LED_COUNT        = DEF_LED_COUNT,
  parameter int unsigned RESET_SEGMENTS   = DEF_RESET_SEGMENTS,
  parameter int unsigned FRAME_DIVISOR    = DEF_FRAME_DIVISOR
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            enable,
  input  logic                            uart_rx,
  output logic                            uart_sample,
  output logic                            segment_strobe,
  output logic                            bit_strobe,
  output logic                            led_strobe,
  output logic [$clog2(BITS_PER_LED)-1:0] bit_index,
  output logic [$clog2(LED_COUNT)-1:0]    led_index,
  output logic                            encoder_reset,
  output logic                            frame_strobe,
  output logic                            frame_overrun,
  output logic                            busy
);

  localparam int unsigned BIT_W   = $clog2(BITS_PER_LED);
  localparam int unsigned LED_W   = $clog2(LED_COUNT);
  localparam int unsigned SEG_W   = cnt_width(SEGMENTS_PER_BIT - 1);
  localparam int unsigned LATCH_W = cnt_width(RESET_SEGMENTS - 1);

  state_t             state_q, state_d;
  logic               rx_meta_q, rx_meta_d;
  logic               rx_sync_q, rx_sync_d;
  logic               rx_prev_q, rx_prev_d;
  logic [SEG_W-1:0]   seg_idx_q, seg_idx_d;
  logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
  logic [LED_W-1:0]   led_idx_q, led_idx_d;
  logic [LATCH_W-1:0] latch_cnt_q, latch_cnt_d;

  logic rx_edge;
  logic frame_tick;
  logic seg_tick;
  logic seg_clear;
  logic seg_run;

  // RX synchroniser idles high so a line held at idle through reset produces no edge.
  always_comb begin
    rx_meta_d = uart_rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
  end

  assign rx_edge   = rx_sync_q != rx_prev_q;
  assign seg_clear = (state_q == IDLE);
  assign seg_run   = (state_q != IDLE);

  led_timing_generator_strobe_divider #(
    .N (FRAME_DIVISOR)
  ) u_frame_div (
    .clock    (clock),
    .reset    (reset),
    .clear    (1'b0),
    .count_en (1'b1),
    .strobe   (frame_tick)
  );

  led_timing_generator_strobe_divider #(
    .N         (UART_DIVISOR),
    .STROBE_AT (UART_DIVISOR / 2 - 1)
  ) u_uart_div (
    .clock    (clock),
    .reset    (reset),
    .clear    (rx_edge),
    .count_en (1'b1),
    .strobe   (uart_sample)
  );

  // The segment divider also paces the latch window, so it keeps running through LATCH.
  led_timing_generator_strobe_divider #(
    .N (SEGMENT_DIVISOR)
  ) u_seg_div (
    .clock    (clock),
    .reset    (reset),
    .clear    (seg_clear),
    .count_en (seg_run),
    .strobe   (seg_tick)
  );

  assign frame_strobe = frame_tick;

  always_comb begin
    state_d        = state_q;
    seg_idx_d      = seg_idx_q;
    bit_idx_d      = bit_idx_q;
    led_idx_d      = led_idx_q;
    latch_cnt_d    = latch_cnt_q;
    segment_strobe = 1'b0;
    bit_strobe     = 1'b0;
    led_strobe     = 1'b0;
    encoder_reset  = 1'b0;
    frame_overrun  = 1'b0;
    busy           = 1'b0;

    case (state_q)
      IDLE: begin
        seg_idx_d   = '0;
        bit_idx_d   = '0;
        led_idx_d   = '0;
        latch_cnt_d = '0;
        if (frame_tick && enable) begin
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        busy           = 1'b1;
        frame_overrun  = frame_tick;
        segment_strobe = seg_tick;
        bit_strobe     = seg_tick && (seg_idx_q == '0);
        led_strobe     = seg_tick && (seg_idx_q == '0) && (bit_idx_q == '0);
        if (seg_tick) begin
          if (seg_idx_q == SEG_W'(SEGMENTS_PER_BIT - 1)) begin
            seg_idx_d = '0;
            if (bit_idx_q == BIT_W'(BITS_PER_LED - 1)) begin
              bit_idx_d = '0;
              if (led_idx_q == LED_W'(LED_COUNT - 1)) begin
                led_idx_d   = '0;
                latch_cnt_d = '0;
                state_d     = LATCH;
              end else begin
                led_idx_d = led_idx_q + LED_W'(1);
              end
            end else begin
              bit_idx_d = bit_idx_q + BIT_W'(1);
            end
          end else begin
            seg_idx_d = seg_idx_q + SEG_W'(1);
          end
        end
      end

      LATCH: begin
        busy          = 1'b1;
        encoder_reset = 1'b1;
        frame_overrun = frame_tick;
        if (seg_tick) begin
          if (latch_cnt_q == LATCH_W'(RESET_SEGMENTS - 1)) begin
            latch_cnt_d = '0;
            state_d     = IDLE;
          end else begin
            latch_cnt_d = latch_cnt_q + LATCH_W'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bit_index = (state_q == SHIFT) ? bit_idx_q : '0;
  assign led_index = (state_q == SHIFT) ? led_idx_q : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      seg_idx_q   <= '0;
      bit_idx_q   <= '0;
      led_idx_q   <= '0;
      latch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      seg_idx_q   <= seg_idx_d;
      bit_idx_q   <= bit_idx_d;
      led_idx_q   <= led_idx_d;
      latch_cnt_q <= latch_cnt_d;
    end
  end

endmodule
